// File: rtl/uart_program_loader.sv
// UART boot loader: receives a framed little-endian program image, writes it word by word
// into instruction memory and holds the core in reset until the image is accepted.
// Optional trailing XOR checksum is enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_program_loader #(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = 115_200,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
`ifdef UART_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERROR
  } ld_state_t;

  // ---------------------------------------------------------------- receiver
  logic             rx_meta, rx_s, rx_prev;
  rx_state_t        rx_state, rx_nxt;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             tick, byte_valid, frame_err;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would make the synchronizer collapse into a single stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign tick = (baud_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_state <= RX_IDLE;
    else        rx_state <= rx_nxt;
  end

  // NOTE: every variable written in always_comb gets a default first; a path that leaves it
  // unassigned would infer a latch.
  always_comb begin
    rx_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s)         rx_nxt = RX_START;
      RX_START: if (tick)                     rx_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7)  rx_nxt = RX_STOP;
      RX_STOP:  if (tick)                     rx_nxt = RX_IDLE;
      default:                                rx_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (rx_state == RX_STOP && tick) begin
      byte_valid = rx_s;
      frame_err  = !rx_s;
    end
  end

  // Idle preloads half a bit so the start bit is re-checked at its centre.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      if (rx_state == RX_IDLE)  baud_cnt <= CNT_W'(HALF_BIT - 1);
      else if (tick)            baud_cnt <= CNT_W'(CLKS_PER_BIT - 1);
      else                      baud_cnt <= baud_cnt - CNT_W'(1);

      if (rx_state == RX_START) bit_idx <= '0;
      if (rx_state == RX_DATA && tick) begin
        rx_byte <= {rx_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // ------------------------------------------------------------------ loader
  ld_state_t   state, state_nxt;
  logic [7:0]  len_lo;
  logic [15:0] len_full, words_left;
  logic [1:0]  byte_idx;
  logic [23:0] word_sr;
  logic        last_byte;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign len_full  = {rx_byte, len_lo};
  assign last_byte = (byte_idx == 2'd3) && (words_left == 16'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_err) begin
      case (state)
        LEN_LO, LEN_HI, DATA: state_nxt = ERROR;
`ifdef UART_LOADER_CHECKSUM_EN
        CSUM:                 state_nxt = ERROR;
`endif
        default: ;
      endcase
    end else if (byte_valid) begin
      case (state)
        WAIT_SYNC, DONE, ERROR: if (rx_byte == SYNC_BYTE) state_nxt = LEN_LO;
        LEN_LO: state_nxt = LEN_HI;
        LEN_HI: begin
          if (len_full == 16'd0 || 33'(len_full) > MAX_WORDS) state_nxt = ERROR;
          else                                                 state_nxt = DATA;
        end
`ifdef UART_LOADER_CHECKSUM_EN
        DATA:   if (last_byte) state_nxt = CSUM;
        CSUM:   state_nxt = (rx_byte == csum) ? DONE : ERROR;
`else
        DATA:   if (last_byte) state_nxt = DONE;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      ERROR:   error = 1'b1;
      default: ;
    endcase
  end

  // Address advances after each write strobe and saturates so a full image cannot wrap it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (mem_we && mem_addr != '1) mem_addr <= mem_addr + ADDR_W'(1);

      if (byte_valid) begin
        case (state)
          LEN_LO: len_lo <= rx_byte;
          LEN_HI: begin
            words_left <= len_full;
            mem_addr   <= '0;
            byte_idx   <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_byte;
`endif
            if (byte_idx == 2'd3) begin
              mem_we     <= 1'b1;
              mem_wdata  <= {rx_byte, word_sr};
              words_left <= words_left - 16'd1;
            end else begin
              word_sr <= {rx_byte, word_sr[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: bit-level UART driver, write scoreboard
// and status checks; adapts expectations to whether UART_LOADER_CHECKSUM_EN is defined.
module tb_uart_program_loader;

  localparam int CLK_HZ = 12_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int ADDR_W = 4;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rx = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_reset, done, error;

  uart_program_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_compared   = 0;
  int          n_mismatched = 0;
  int          wr_cnt       = 0;
  logic [31:0] img [16];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic c, input logic d, input logic e);
    check({tag, ".cpu_reset"}, 64'(cpu_reset), 64'(c));
    check({tag, ".done"},      64'(done),      64'(d));
    check({tag, ".error"},     64'(error),     64'(e));
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (reset && mem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", 64'(mem_we), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr),  64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    if (!stop_bit) begin
      rx = 1'b1;
      repeat (CPB) @(posedge clk);
    end
  endtask

  // Sends a complete frame of img[0..n-1]; the trailing byte is the payload XOR
  // with csum_flip applied (a nonzero flip corrupts it).
  task automatic send_image(input int n, input logic [7:0] csum_flip, input bit skip_sync = 1'b0);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    x = 8'h00;
    if (!skip_sync) send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_q.push_back('{addr: ADDR_W'(i), data: w});
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        x = x ^ b;
        send_byte(b);
      end
    end
    send_byte(x ^ csum_flip);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin : stim
    int base;

    // Reset state and quiet idle line
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_status("por", 1'b1, 1'b0, 1'b0);
    check("por.mem_we",    64'(mem_we),    64'(0));
    check("por.mem_addr",  64'(mem_addr),  64'(0));
    check("por.mem_wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b1;
    repeat (1000) @(negedge clk);
    check_status("idle", 1'b1, 1'b0, 1'b0);
    check("idle.writes", 64'(wr_cnt), 64'(0));

    // Single-word image with correct checksum 0x43
    base = wr_cnt;
    img[0] = 32'h0050_0013;
    send_image(1, 8'h00);
    settle();
    check_status("one_word", 1'b0, 1'b1, 1'b0);
    check("one_word.writes", 64'(wr_cnt - base), 64'(1));

    // Sync from DONE reasserts cpu_reset; then a two-word image
    base = wr_cnt;
    send_byte(8'hA5);
    settle();
    check_status("resync", 1'b1, 1'b0, 1'b0);
    img[0] = 32'h0010_0093;
    img[1] = 32'h0000_006F;
    send_image(2, 8'h00, 1'b1);
    settle();
    check_status("two_word", 1'b0, 1'b1, 1'b0);
    check("two_word.writes", 64'(wr_cnt - base), 64'(2));

    // Bad checksum (0x44 instead of 0x43): word still written
    base = wr_cnt;
    img[0] = 32'h0050_0013;
    send_image(1, 8'h07);
    settle();
    check_status("bad_csum", CK, !CK, CK);
    check("bad_csum.writes", 64'(wr_cnt - base), 64'(1));
    send_byte(8'hA5);
    settle();
    check_status("bad_csum.resync", 1'b1, 1'b0, 1'b0);
    send_image(1, 8'h00, 1'b1);
    settle();
    check_status("recover", 1'b0, 1'b1, 1'b0);

    // Maximum length image: 16 words fill the memory
    base = wr_cnt;
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    send_image(16, 8'h00);
    settle();
    check_status("full", 1'b0, 1'b1, 1'b0);
    check("full.writes", 64'(wr_cnt - base), 64'(16));

    // Length out of range (17) and zero length
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h11); send_byte(8'h00);
    settle();
    check_status("len17", 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    settle();
    check("len0.error_cleared", 64'(error), 64'(0));
    send_byte(8'h00); send_byte(8'h00);
    settle();
    check_status("len0", 1'b1, 1'b0, 1'b1);
    check("len.writes", 64'(wr_cnt - base), 64'(0));

    // Framing error on the second payload byte
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00, 1'b0);
    settle();
    check_status("stop_low", 1'b1, 1'b0, 1'b1);
    check("stop_low.writes", 64'(wr_cnt - base), 64'(0));

    // In WAIT_SYNC: a sync byte with bad stop and a stray 0x5A are ignored
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    base = wr_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A);
    send_byte(8'h01);
    settle();
    check_status("wait_sync", 1'b1, 1'b0, 1'b0);
    check("wait_sync.writes", 64'(wr_cnt - base), 64'(0));

    // Reset mid-payload, then a clean reload
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h13);
    rx = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    check_status("mid_reset", 1'b1, 1'b0, 1'b0);
    check("mid_reset.mem_we",    64'(mem_we),    64'(0));
    check("mid_reset.mem_addr",  64'(mem_addr),  64'(0));
    check("mid_reset.mem_wdata", 64'(mem_wdata), 64'(0));
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    base = wr_cnt;
    img[0] = 32'h0050_0013;
    send_image(1, 8'h00);
    settle();
    check_status("reload", 1'b0, 1'b1, 1'b0);
    check("reload.writes", 64'(wr_cnt - base), 64'(1));

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
